rw_severity_monitor: RTL and testbench
======================================

# rw_severity_monitor

Synthesizable, parametrised run-time checker for N read/write channels. Each cycle it flags a warning when a channel's `valid` is low and an error when `wr_en` and `rd_en` are both high. It keeps saturating warning and error counters and escalates through a sticky severity state machine (OK → WARN → FAIL), with an optional mode that promotes warnings to errors. It sits beside the channel arbiter in DV-enabled builds and drives an interrupt and status into the debug register block.

## Interface
Parameters:
- `NUM_CH`, 4 — number of monitored channels (≥1)
- `CNT_W`, 8 — width of each counter
- `WARN_LIMIT`, 14 — warning count that enters WARN
- `ERR_LIMIT`, 15 — error count that enters FAIL
- `ESCALATE`, 0 — 1: warnings counted while in WARN also increment `err_cnt`

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1 — sampling clock, posedge
- `rst_n` input 1 — async active-low reset
- `en` input 1 — monitor enable; when low, no hits are counted
- `clr` input 1 — synchronous clear of all counters, flags and state
- `wr_en` input NUM_CH — per-channel write enable
- `rd_en` input NUM_CH — per-channel read enable
- `valid` input NUM_CH — per-channel valid
- `warn_cnt` output CNT_W — saturating warning count
- `err_cnt` output CNT_W — saturating error count
- `state` output 2 — OK=0, WARN=1, FAIL=2
- `irq` output 1 — one-cycle pulse on any state change
- `ch_err_sticky` output NUM_CH — per-channel error seen since clear
- `first_err_ch` output max(1,$clog2(NUM_CH)) — first erroring channel
- `first_err_vld` output 1 — `first_err_ch` is valid

## Operation
- Per channel i, when `en`=1: `warn_hit[i] = ~valid[i]`; `err_hit[i] = wr_en[i] & rd_en[i]`. Both can fire on the same channel in the same cycle.
- Warning increment = popcount(`warn_hit`).
- Error increment = popcount(`err_hit`), plus popcount(`warn_hit`) when `ESCALATE`=1 and registered `state`==WARN.
- Counters add their increment with saturation at 2^CNT_W−1 and never wrap.
- State transitions are evaluated on the next-cycle counter values:
  - any state → FAIL if next `err_cnt` ≥ ERR_LIMIT
  - else OK → WARN if next `warn_cnt` ≥ WARN_LIMIT
  - FAIL and WARN are sticky until `clr` or reset
  - if both thresholds are crossed in one cycle, go straight to FAIL with a single `irq` pulse
- `ch_err_sticky[i]` is set on `err_hit[i]` and cleared only by `clr` or reset.
- First-error capture: in the cycle where `err_cnt` was 0 and an `err_hit` occurs, `first_err_ch` takes the lowest-index erroring channel and `first_err_vld` is set. The capture then holds. An escalated warning alone does not capture.
- `clr` has priority over hits in the same cycle: hits in that cycle are discarded. The result is counters 0, state OK, flags 0, `irq` 0.
- `en`=0 freezes all state. `clr` still acts while `en`=0.

## Timing
- All outputs are registered. A hit sampled at posedge k is visible after posedge k, i.e. 1-cycle latency.
- `irq` is high for exactly the one cycle in which `state` shows its new value.
- On `rst_n` low, all outputs go to 0 immediately, regardless of `clk`; `state` = OK. Reset may assert mid-operation; no partial counts survive.
- Release of `rst_n` is synchronised externally; the block makes no assumption beyond async assert.

## Structure
- Package `rw_mon_pkg`: `mon_state_e` enum (OK/WARN/FAIL, 2 bits) and the `ch_idx_w(NUM_CH)` function.
- Sub-module `sat_accum #(W, N)`: popcount of an N-bit hit vector plus saturating add and sync clear. It is instantiated twice; the error instance takes a 2N-bit vector (err hits concatenated with gated warn hits).
- The top level holds the FSM, sticky flags, first-error capture and `irq`.

## Test plan
- **Basic escalation** (NUM_CH=1, defaults): 4 clean cycles, then 20 cycles of wr=rd=1, valid=0.
  - `state` goes WARN after the 14th violation cycle (`irq` pulse).
  - FAIL after the 15th (second `irq`).
  - Final `warn_cnt`=20, `err_cnt`=20.
- **Saturation** (CNT_W=4, WARN_LIMIT=20): 20 cycles of valid=0 → `warn_cnt` holds at 15 with no wrap; `state` stays OK.
- **Multi-channel** (NUM_CH=4): one cycle with err on channels 1 and 3 → `err_cnt`=2, `ch_err_sticky`=4'b1010, `first_err_ch`=1, `first_err_vld`=1. A later err on ch0 leaves `first_err_ch`=1.
- **Escalation mode** (ESCALATE=1, WARN_LIMIT=2, ERR_LIMIT=5): valid=0 on ch0 only, every cycle.
  - WARN after cycle 2.
  - `err_cnt` increments from cycle 3 onward.
  - FAIL after cycle 7.
  - `first_err_vld` stays 0.
- **Clear and enable**: `clr` asserted together with 4 err hits → next cycle all counters 0, OK, `irq` 0. With `en`=0 and violations for 5 cycles, counters are unchanged.
- **Async reset mid-run**: drop `rst_n` between clock edges while in WARN → all outputs 0 before the next posedge; normal counting resumes after release.

Source files
------------

// File: rtl/rw_mon_pkg.sv
// Shared types and helpers for the read/write severity monitor.
package rw_mon_pkg;

    // Severity levels, encoded as they appear on the status port.
    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_WARN = 2'd1,
        ST_FAIL = 2'd2
    } mon_state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator: adds the popcount of a hit vector each cycle.
module sat_accum #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic [N-1:0] i_hits,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_cnt_nxt_c
);

    localparam int unsigned PW = $clog2(N + 1);
    localparam int unsigned SW = ((W > PW) ? W : PW) + 1;

    logic [W-1:0]  r_cnt;
    logic [PW-1:0] w_pop;
    logic [SW-1:0] w_sum;

    // Count the set bits of the hit vector.
    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_pop = w_pop + PW'(i_hits[i]);
        end
    end

    // Next count: clear wins, otherwise add and clamp at all-ones.
    always_comb begin
        w_sum = SW'(r_cnt) + SW'(w_pop);
        if (i_clr) begin
            o_cnt_nxt_c = '0;
        end else if (w_sum > SW'({W{1'b1}})) begin
            o_cnt_nxt_c = {W{1'b1}};
        end else begin
            o_cnt_nxt_c = W'(w_sum);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_cnt_nxt_c;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rw_severity_monitor.sv
// Run-time read/write protocol checker with sticky OK/WARN/FAIL severity.
module rw_severity_monitor
    import rw_mon_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned WARN_LIMIT = 14,
    parameter int unsigned ERR_LIMIT  = 15,
    parameter int unsigned ESCALATE   = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        clr,
    input  logic [NUM_CH-1:0]           wr_en,
    input  logic [NUM_CH-1:0]           rd_en,
    input  logic [NUM_CH-1:0]           valid,
    output logic [CNT_W-1:0]            warn_cnt,
    output logic [CNT_W-1:0]            err_cnt,
    output logic [1:0]                  state,
    output logic                        irq,
    output logic [NUM_CH-1:0]           ch_err_sticky,
    output logic [ch_idx_w(NUM_CH)-1:0] first_err_ch,
    output logic                        first_err_vld
);

    localparam int unsigned IDX_W = ch_idx_w(NUM_CH);

    mon_state_e        r_state;
    mon_state_e        w_state_nxt;
    logic              r_irq;
    logic              w_irq_nxt;
    logic [NUM_CH-1:0] r_sticky;
    logic [IDX_W-1:0]  r_first_ch;
    logic              r_first_vld;
    logic [IDX_W-1:0]  w_first_idx;

    logic [NUM_CH-1:0] w_warn_hit;
    logic [NUM_CH-1:0] w_err_hit;
    logic [NUM_CH-1:0] w_esc_hit;
    logic [CNT_W-1:0]  w_warn_cnt;
    logic [CNT_W-1:0]  w_err_cnt;
    logic [CNT_W-1:0]  w_warn_nxt;
    logic [CNT_W-1:0]  w_err_nxt;

    // Per-channel hits; a disabled monitor sees nothing.
    assign w_warn_hit = en ? ~valid : '0;
    assign w_err_hit  = en ? (wr_en & rd_en) : '0;
    // Warnings taken while already in WARN also count as errors in escalate mode.
    assign w_esc_hit  = ((ESCALATE != 0) && (r_state == ST_WARN)) ? w_warn_hit : '0;

    sat_accum #(.W(CNT_W), .N(NUM_CH)) u_warn_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (clr),
        .i_hits      (w_warn_hit),
        .o_cnt       (w_warn_cnt),
        .o_cnt_nxt_c (w_warn_nxt)
    );

    sat_accum #(.W(CNT_W), .N(2 * NUM_CH)) u_err_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (clr),
        .i_hits      ({w_esc_hit, w_err_hit}),
        .o_cnt       (w_err_cnt),
        .o_cnt_nxt_c (w_err_nxt)
    );

    // Severity state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next severity from next-cycle counts; FAIL outranks WARN, both sticky.
    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = 1'b0;
        if (clr) begin
            w_state_nxt = ST_OK;
        end else begin
            if (32'(w_err_nxt) >= ERR_LIMIT) begin
                w_state_nxt = ST_FAIL;
            end else if ((r_state == ST_OK) && (32'(w_warn_nxt) >= WARN_LIMIT)) begin
                w_state_nxt = ST_WARN;
            end
            w_irq_nxt = (w_state_nxt != r_state);
        end
    end

    // Lowest-index erroring channel this cycle.
    always_comb begin
        w_first_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (w_err_hit[i]) begin
                w_first_idx = IDX_W'(i);
            end
        end
    end

    // Interrupt pulse, sticky channel flags and first-error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq       <= 1'b0;
            r_sticky    <= '0;
            r_first_ch  <= '0;
            r_first_vld <= 1'b0;
        end else if (clr) begin
            r_irq       <= 1'b0;
            r_sticky    <= '0;
            r_first_ch  <= '0;
            r_first_vld <= 1'b0;
        end else begin
            r_irq    <= w_irq_nxt;
            r_sticky <= r_sticky | w_err_hit;
            if ((w_err_cnt == '0) && (|w_err_hit)) begin
                r_first_ch  <= w_first_idx;
                r_first_vld <= 1'b1;
            end
        end
    end

    assign warn_cnt      = w_warn_cnt;
    assign err_cnt       = w_err_cnt;
    assign state         = r_state;
    assign irq           = r_irq;
    assign ch_err_sticky = r_sticky;
    assign first_err_ch  = r_first_ch;
    assign first_err_vld = r_first_vld;

endmodule

// File: tb/tb_rw_severity_monitor.sv
// Self-checking bench for rw_severity_monitor: directed scenarios plus random traffic.
module tb_rw_severity_monitor;

    localparam int NCH  = 4;
    localparam int CW   = 5;
    localparam int WL   = 6;
    localparam int EL   = 8;
    localparam int ESC  = 1;
    localparam int MAXC = (1 << CW) - 1;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           clr;
    logic [NCH-1:0] wr_en;
    logic [NCH-1:0] rd_en;
    logic [NCH-1:0] valid;
    logic [CW-1:0]  warn_cnt;
    logic [CW-1:0]  err_cnt;
    logic [1:0]     state;
    logic           irq;
    logic [NCH-1:0] ch_err_sticky;
    logic [1:0]     first_err_ch;
    logic           first_err_vld;

    rw_severity_monitor #(
        .NUM_CH(NCH), .CNT_W(CW), .WARN_LIMIT(WL), .ERR_LIMIT(EL), .ESCALATE(ESC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .wr_en(wr_en), .rd_en(rd_en), .valid(valid),
        .warn_cnt(warn_cnt), .err_cnt(err_cnt), .state(state), .irq(irq),
        .ch_err_sticky(ch_err_sticky), .first_err_ch(first_err_ch),
        .first_err_vld(first_err_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer bookkeeping of the monitor's rules.
    typedef struct {
        int warn;
        int err;
        int st;
        int irq;
        int sticky;
        int first;
        int fvld;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t cur, input logic e, input logic c,
                                           input logic [NCH-1:0] w, input logic [NCH-1:0] r,
                                           input logic [NCH-1:0] v);
        mstate_t nx;
        int wh, eh, ns, fi;
        nx = cur;
        if (c) begin
            nx = '{0, 0, 0, 0, 0, 0, 0};
        end else if (!e) begin
            nx.irq = 0;
        end else begin
            wh = $countones(~v);
            eh = $countones(w & r);
            nx.warn = cur.warn + wh;
            nx.err  = cur.err + eh + ((ESC != 0 && cur.st == 1) ? wh : 0);
            if (nx.warn > MAXC) nx.warn = MAXC;
            if (nx.err > MAXC) nx.err = MAXC;
            ns = cur.st;
            if (nx.err >= EL) ns = 2;
            else if (cur.st == 0 && nx.warn >= WL) ns = 1;
            nx.irq = (ns != cur.st) ? 1 : 0;
            nx.st  = ns;
            nx.sticky = cur.sticky | int'(w & r);
            if (cur.err == 0 && eh > 0) begin
                fi = 0;
                for (int i = NCH - 1; i >= 0; i--) if (w[i] & r[i]) fi = i;
                nx.first = fi;
                nx.fvld  = 1;
            end
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{0, 0, 0, 0, 0, 0, 0};
        else        m <= model_next(m, en, clr, wr_en, rd_en, valid);
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("warn_cnt",      int'(warn_cnt),      m.warn);
            cmp("err_cnt",       int'(err_cnt),       m.err);
            cmp("state",         int'(state),         m.st);
            cmp("irq",           int'(irq),           m.irq);
            cmp("ch_err_sticky", int'(ch_err_sticky), m.sticky);
            cmp("first_err_vld", int'(first_err_vld), m.fvld);
            if (m.fvld != 0) cmp("first_err_ch", int'(first_err_ch), m.first);
        end
    end

    // Apply one cycle of inputs at a negedge, return at the following negedge.
    task automatic step(input logic e, input logic c, input logic [NCH-1:0] w,
                        input logic [NCH-1:0] r, input logic [NCH-1:0] v);
        en = e; clr = c; wr_en = w; rd_en = r; valid = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        wr_en = '0; rd_en = '0; valid = '1;
        @(negedge clk); @(negedge clk);
        cmp("rst_warn", int'(warn_cnt), 0);
        cmp("rst_err",  int'(err_cnt), 0);
        cmp("rst_state", int'(state), 0);
        cmp("rst_fvld", int'(first_err_vld), 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Errors on channels 1 and 3, then channel 0.
        step(1, 0, 4'b1010, 4'b1010, 4'hF);
        cmp("mc_err", int'(err_cnt), 2);
        cmp("mc_sticky", int'(ch_err_sticky), 4'b1010);
        cmp("mc_first", int'(first_err_ch), 1);
        cmp("mc_fvld", int'(first_err_vld), 1);
        step(1, 0, 4'b0001, 4'b0001, 4'hF);
        cmp("mc_first_hold", int'(first_err_ch), 1);
        cmp("mc_sticky2", int'(ch_err_sticky), 4'b1011);

        // Clear beats simultaneous hits.
        step(1, 1, 4'hF, 4'hF, 4'h0);
        cmp("clr_err", int'(err_cnt), 0);
        cmp("clr_warn", int'(warn_cnt), 0);
        cmp("clr_state", int'(state), 0);
        cmp("clr_irq", int'(irq), 0);
        cmp("clr_sticky", int'(ch_err_sticky), 0);

        // Escalation: ch0 invalid every cycle.
        repeat (6) step(1, 0, 4'h0, 4'h0, 4'b1110);
        cmp("esc_warn_state", int'(state), 1);
        cmp("esc_warn_irq", int'(irq), 1);
        cmp("esc_err0", int'(err_cnt), 0);
        step(1, 0, 4'h0, 4'h0, 4'b1110);
        cmp("esc_err1", int'(err_cnt), 1);
        cmp("esc_irq_drop", int'(irq), 0);
        cmp("esc_fvld", int'(first_err_vld), 0);

        // Disabled monitor ignores violations.
        repeat (5) step(0, 0, 4'hF, 4'hF, 4'h0);
        cmp("en0_warn", int'(warn_cnt), 7);
        cmp("en0_err", int'(err_cnt), 1);

        repeat (7) step(1, 0, 4'h0, 4'h0, 4'b1110);
        cmp("esc_fail_state", int'(state), 2);
        cmp("esc_fail_irq", int'(irq), 1);
        cmp("esc_fail_err", int'(err_cnt), 8);
        cmp("esc_fail_warn", int'(warn_cnt), 14);

        // Warning saturation; no escalation once in FAIL.
        repeat (18) step(1, 0, 4'h0, 4'h0, 4'b1110);
        cmp("sat_warn", int'(warn_cnt), 31);
        cmp("fail_err_hold", int'(err_cnt), 8);
        cmp("fail_sticky_state", int'(state), 2);

        // Both thresholds crossed in one cycle: straight to FAIL.
        step(1, 1, 4'h0, 4'h0, 4'hF);
        step(1, 0, 4'hF, 4'hF, 4'h0);
        cmp("both1_state", int'(state), 0);
        step(1, 0, 4'hF, 4'hF, 4'h0);
        cmp("both2_state", int'(state), 2);
        cmp("both2_irq", int'(irq), 1);
        step(1, 0, 4'h0, 4'h0, 4'hF);
        cmp("both3_irq", int'(irq), 0);

        // Async reset in WARN, between clock edges.
        step(1, 1, 4'h0, 4'h0, 4'hF);
        repeat (6) step(1, 0, 4'h0, 4'h0, 4'b1110);
        cmp("pre_rst_state", int'(state), 1);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_warn", int'(warn_cnt), 0);
        cmp("arst_state", int'(state), 0);
        cmp("arst_irq", int'(irq), 0);
        cmp("arst_err", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 4'h0, 4'h0, 4'b1110);
        cmp("post_rst_warn", int'(warn_cnt), 1);

        // Random traffic checked by the model every cycle.
        for (int p = 0; p < 25; p++) begin
            int wp, ep;
            logic [NCH-1:0] w, r, v;
            wp = int'($urandom_range(1, 8));
            ep = int'($urandom_range(2, 16));
            step(1, 1, 4'(($urandom)), 4'(($urandom)), 4'(($urandom)));
            for (int c = 0; c < 60; c++) begin
                for (int i = 0; i < NCH; i++) begin
                    v[i] = ($urandom_range(0, wp) != 0);
                    if ($urandom_range(0, ep) == 0) begin
                        w[i] = 1'b1; r[i] = 1'b1;
                    end else begin
                        w[i] = 1'($urandom_range(0, 1));
                        r[i] = ~w[i] & 1'($urandom_range(0, 1));
                    end
                end
                step(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), w, r, v);
            end
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
